// File: rtl/bram_uart_dumper_pkg.sv
// Shared types and sizing helpers for the BRAM-to-UART dump path.
package bram_uart_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT
  } dump_state_t;

  localparam int WORD_WIDTH_DEF = 32;
  localparam int BYTES_PER_WORD = WORD_WIDTH_DEF / 8;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Counter width that never collapses to zero bits for single-value ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one word and presents it a byte at a time, LSB first; load/advance take effect next cycle.
// No backpressure of its own: the caller decides when to advance.
module word_byte_serializer
  import bram_uart_dumper_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in_n,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  advance_i,
  output logic [7:0]            byte_o,
  output logic                  last_o
);

  localparam int BPW  = WORD_WIDTH / 8;
  localparam int IDXW = idx_width(BPW);

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDXW-1:0]       idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = word_i;
      idx_d   = '0;
    end else if (advance_i) begin
      shreg_d = shreg_q >> 8;
      if (!last_o) idx_d = idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_o = shreg_q[7:0];
  assign last_o = (idx_q == IDXW'(BPW - 1));

endmodule

// File: rtl/bram_uart_dumper.sv
// Streams count words from BRAM starting at base to uart_transmit, LSB byte first; first trigger 4 cycles after start.
// Backpressure: waits for uart busy to rise then fall after every trigger before the next byte.
module bram_uart_dumper
  import bram_uart_dumper_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH        = 25251,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in_n,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   count_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  uart_busy_in,
  output logic                  uart_trigger_out,
  output logic [7:0]            uart_byte_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [ADDR_WIDTH:0]   words_sent_out
);

  localparam int LATW = idx_width(READ_LATENCY + 1);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [LATW-1:0]       lat_q, lat_d;
  logic [7:0]            byte_q, byte_d;
  logic                  done_q, done_d;

  logic                  ser_load, ser_adv, ser_last, trig;
  logic [7:0]            ser_byte;

  word_byte_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .load_i   (ser_load),
    .word_i   (data_in),
    .advance_i(ser_adv),
    .byte_o   (ser_byte),
    .last_o   (ser_last)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    words_d  = words_q;
    lat_d    = lat_q;
    byte_d   = byte_q;
    done_d   = 1'b0;
    ser_load = 1'b0;
    ser_adv  = 1'b0;
    trig     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          count_d = count_in;
          words_d = '0;
          lat_d   = '0;
          if (count_in == '0) begin
            state_d = ST_NEXT;
          end else begin
            addr_d  = base_addr_in;
            state_d = ST_FETCH;
          end
        end
      end
      // Address went out on entry; data is safe once the counter reaches the latency.
      ST_FETCH: begin
        if (lat_q == LATW'(READ_LATENCY)) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end else begin
          lat_d = lat_q + LATW'(1);
        end
      end
      ST_SEND: begin
        if (!uart_busy_in) begin
          trig    = 1'b1;
          byte_d  = ser_byte;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (uart_busy_in) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!uart_busy_in) begin
          ser_adv = 1'b1;
          if (ser_last) begin
            words_d = words_q + 1'b1;
            state_d = ST_NEXT;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_NEXT: begin
        if (words_q == count_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          lat_d   = '0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      words_q <= '0;
      lat_q   <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      words_q <= words_d;
      lat_q   <= lat_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  // Byte is valid in the trigger cycle and then held by byte_q until the next trigger.
  assign uart_trigger_out = trig;
  assign uart_byte_out    = trig ? ser_byte : byte_q;
  assign addr_out         = addr_q;
  assign busy_out         = (state_q != ST_IDLE);
  assign done_out         = done_q;
  assign words_sent_out   = words_q;

endmodule

// File: tb/tb_bram_uart_dumper.sv
// Directed bench with a BRAM model, a UART busy model and a byte scoreboard checked by a monitor.
module tb_bram_uart_dumper;

  localparam int DEPTH = 25251;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [AW-1:0] addr_out;
  logic [31:0]   data_in;
  logic          uart_busy;
  logic          trig;
  logic [7:0]    ubyte;
  logic          busy_out;
  logic          done_out;
  logic [AW:0]   words_sent;

  bram_uart_dumper #(
    .WORD_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2)
  ) dut (
    .clk_in          (clk),
    .rst_in_n        (rst_n),
    .start_in        (start),
    .base_addr_in    (base),
    .count_in        (count),
    .addr_out        (addr_out),
    .data_in         (data_in),
    .uart_busy_in    (uart_busy),
    .uart_trigger_out(trig),
    .uart_byte_out   (ubyte),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .words_sent_out  (words_sent)
  );

  always #5 clk = ~clk;

  // Two-stage BRAM read pipe
  logic [31:0]   mem [0:DEPTH-1];
  logic [AW-1:0] a1;
  always @(posedge clk) begin
    a1      <= addr_out;
    data_in <= mem[a1];
  end

  // UART model: busy rises the cycle after a trigger and lasts busy_len cycles
  int busy_len = 10;
  int ucnt = 0;
  always @(posedge clk) begin
    if (trig && ucnt == 0) ucnt <= busy_len;
    else if (ucnt > 0)     ucnt <= ucnt - 1;
  end
  assign uart_busy = (ucnt > 0);

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] last_addr = '0;
  int edge_n = 0;
  int start_edge = 0, first_trig_edge = -1, done_edge = -1;
  int trig_cnt = 0, done_cnt = 0, busy_cycles = 0;
  logic prev_trig = 1'b0;

  always @(posedge clk) edge_n++;

  // Monitor: runs on the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (start && !busy_out && rst_n) begin
      start_edge      = edge_n + 1;
      first_trig_edge = -1;
      done_edge       = -1;
      trig_cnt        = 0;
      busy_cycles     = 0;
    end
    if (busy_out) busy_cycles++;
    if (trig) begin
      trig_cnt++;
      if (first_trig_edge < 0) first_trig_edge = edge_n + 1;
      check("trig_while_busy", {63'd0, uart_busy}, 64'd0);
      check("trig_back_to_back", {63'd0, prev_trig}, 64'd0);
      if (exp_q.size() == 0) check("unexpected_trigger", 64'd1, 64'd0);
      else check("byte", {56'd0, ubyte}, {56'd0, exp_q.pop_front()});
    end
    prev_trig = trig;
    if (done_out) begin
      done_cnt++;
      done_edge = edge_n + 1;
    end
    if (addr_out != last_addr) begin
      addr_log.push_back(addr_out);
      last_addr = addr_out;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] c);
    @(posedge clk); #1;
    base = b; count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < maxc) begin
      @(negedge clk); k++;
    end
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, {49'd0, addr_out}, 64'd0);
    check({tag, "_trig"}, {63'd0, trig}, 64'd0);
    check({tag, "_byte"}, {56'd0, ubyte}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy_out}, 64'd0);
    check({tag, "_done"}, {63'd0, done_out}, 64'd0);
    check({tag, "_words"}, {48'd0, words_sent}, 64'd0);
  endtask

  initial begin
    int d0;
    int k;
    rst_n = 1'b0; start = 1'b0; base = '0; count = '0;
    mem[5]       = 32'hDDCCBBAA;
    mem[DEPTH-1] = 32'h04030201;
    mem[0]       = 32'h08070605;
    mem[10]      = 32'h44332211;
    mem[11]      = 32'h88776655;
    mem[20]      = 32'hEEEEEEEE;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single word, LSB byte first
    d0 = done_cnt;
    push_word(32'hDDCCBBAA);
    do_start(AW'(5), (AW+1)'(1));
    wait_done(2000);
    check("w1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("w1_words", {48'd0, words_sent}, 64'd1);
    check("w1_trigs", 64'(trig_cnt), 64'd4);
    check("w1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero count: no triggers, done two edges after start
    d0 = done_cnt;
    do_start(AW'(7), '0);
    wait_done(50);
    check("c0_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("c0_trigs", 64'(trig_cnt), 64'd0);
    check("c0_done_edge", 64'(done_edge - start_edge), 64'd2);
    check("c0_busy_cycles", 64'(busy_cycles), 64'd1);
    check("c0_words", {48'd0, words_sent}, 64'd0);

    // Address wrap from DEPTH-1 to 0
    addr_log.delete();
    push_word(32'h04030201);
    push_word(32'h08070605);
    do_start(AW'(DEPTH-1), (AW+1)'(2));
    wait_done(4000);
    check("wrap_addr_count", 64'(addr_log.size()), 64'd2);
    if (addr_log.size() >= 2) begin
      check("wrap_addr0", {49'd0, addr_log[0]}, 64'(DEPTH-1));
      check("wrap_addr1", {49'd0, addr_log[1]}, 64'd0);
    end
    check("wrap_trigs", 64'(trig_cnt), 64'd8);
    check("wrap_words", {48'd0, words_sent}, 64'd2);

    // Long busy, second start mid-run must be ignored
    busy_len = 200;
    d0 = done_cnt;
    push_word(32'h44332211);
    push_word(32'h88776655);
    do_start(AW'(10), (AW+1)'(2));
    k = 0;
    while (trig_cnt < 2 && k < 1000) begin @(negedge clk); k++; end
    check("hs_reached_trig2", 64'(trig_cnt >= 2), 64'd1);
    do_start(AW'(20), (AW+1)'(1));
    wait_done(5000);
    check("hs_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("hs_trigs", 64'(trig_cnt), 64'd8);
    check("hs_words", {48'd0, words_sent}, 64'd2);
    check("hs_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset during third byte, then a fresh run for latency
    busy_len = 10;
    d0 = done_cnt;
    push_word(32'hDDCCBBAA);
    do_start(AW'(5), (AW+1)'(1));
    k = 0;
    while (trig_cnt < 3 && k < 500) begin @(negedge clk); k++; end
    check("rst_reached_trig3", 64'(trig_cnt), 64'd3);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    push_word(32'hDDCCBBAA);
    do_start(AW'(5), (AW+1)'(1));
    wait_done(2000);
    check("lat_first_trig", 64'(first_trig_edge - start_edge), 64'd4);
    check("lat_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("lat_words", {48'd0, words_sent}, 64'd1);
    check("lat_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
